// File: rtl/ptp_pkg.sv
// Shared definitions for the PTP packet mux: word layout, header codes, FSM encodings.
package ptp_pkg;
  localparam int PKT_W = 134;

  localparam logic [1:0] PKT_HEAD = 2'b01;
  localparam logic [1:0] PKT_BODY = 2'b11;
  localparam logic [1:0] PKT_TAIL = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND_A = 3'd1;
  localparam logic [2:0] ST_SEND_B = 3'd2;
  localparam logic [2:0] ST_DROP_A = 3'd3;
  localparam logic [2:0] ST_DROP_B = 3'd4;

  typedef logic [PKT_W-1:0] pkt_word_t;

  function automatic logic [1:0] pkt_hdr(input pkt_word_t w);
    return w[PKT_W-1 -: 2];
  endfunction
endpackage

// File: rtl/ptp_pkt_mux_if.sv
// One packet stream: word strobe/data, end-of-packet keep flag, and reverse almost-full.
interface ptp_pkt_mux_if;
  import ptp_pkg::*;

  logic      data_wr;
  pkt_word_t data;
  logic      data_valid;
  logic      data_valid_wr;
  logic      data_alf;

  modport master (output data_wr, data, data_valid, data_valid_wr, input data_alf);
  modport slave  (input data_wr, data, data_valid, data_valid_wr, output data_alf);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   used_nxt_o
);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wptr_q, rptr_q, used;
  logic         push, pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop frees the slot in the same cycle, so a write at full still lands.
  assign pop     = rd_i && !empty_o;
  assign push    = wr_i && (!full_o || pop);
  assign used    = wptr_q - rptr_q;
  assign used_nxt_o = used + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ONE;
      if (pop)  rptr_q <= rptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/ptp_pkt_mux.sv
// Store-and-forward merge of the forwarded stream (A) and local PTP stream (B), packet round-robin.
module ptp_pkt_mux
  import ptp_pkg::*;
#(
  parameter int DATA_AW    = 8,
  parameter int VLD_AW     = 4,
  parameter int ALF_MARGIN = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  ptp_pkt_mux_if.slave  a_if,
  ptp_pkt_mux_if.slave  b_if,
  ptp_pkt_mux_if.master out_if,
  output logic [15:0]   ovf_cnt
);
  // free < MARGIN is the same as used > depth - MARGIN
  localparam logic [DATA_AW:0] D_ALF_TH = (DATA_AW+1)'(2**DATA_AW - ALF_MARGIN);
  localparam logic [VLD_AW:0]  F_ALF_TH = (VLD_AW+1)'(2**VLD_AW - 2);

  logic [1:0] d_wr, d_rd, d_full, d_empty;
  logic [1:0] f_wr, f_din, f_rd, f_full, f_empty, f_head;
  logic [1:0] alf_d, alf_q, want;
  pkt_word_t  d_din  [2];
  pkt_word_t  d_dout [2];
  logic [DATA_AW:0] d_used [2];
  logic [VLD_AW:0]  f_used [2];

  logic [2:0]  state_q, state_d;
  logic        rr_q, rr_d, sel, emit, any_ovf;
  logic [1:0]  hdr;
  logic [15:0] ovf_q;
  logic        out_wr_q, out_vld_q, out_vwr_q;
  pkt_word_t   out_data_q;

  assign d_wr     = {b_if.data_wr, a_if.data_wr};
  assign f_wr     = {b_if.data_valid_wr, a_if.data_valid_wr};
  assign f_din    = {b_if.data_valid, a_if.data_valid};
  assign d_din[0] = a_if.data;
  assign d_din[1] = b_if.data;

  for (genvar p = 0; p < 2; p++) begin : g_port
    sync_fifo #(.W(PKT_W), .AW(DATA_AW)) u_dfifo (
      .clk(clk), .rst_n(rst_n), .wr_i(d_wr[p]), .wdata_i(d_din[p]), .rd_i(d_rd[p]),
      .rdata_o(d_dout[p]), .full_o(d_full[p]), .empty_o(d_empty[p]), .used_nxt_o(d_used[p]));
    sync_fifo #(.W(1), .AW(VLD_AW)) u_ffifo (
      .clk(clk), .rst_n(rst_n), .wr_i(f_wr[p]), .wdata_i(f_din[p]), .rd_i(f_rd[p]),
      .rdata_o(f_head[p]), .full_o(f_full[p]), .empty_o(f_empty[p]), .used_nxt_o(f_used[p]));

    assign alf_d[p] = (d_used[p] > D_ALF_TH) || (f_used[p] >= F_ALF_TH);
    // Drops proceed under downstream back-pressure; sends wait for it to clear.
    assign want[p]  = !f_empty[p] && !d_empty[p] && (!f_head[p] || !out_if.data_alf);
  end

  assign any_ovf = |((d_wr & d_full & ~d_rd) | (f_wr & f_full & ~f_rd));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    d_rd    = '0;
    f_rd    = '0;
    emit    = 1'b0;
    case (state_q)
      ST_IDLE:              sel = (want == 2'b11) ? rr_q : want[1];
      ST_SEND_B, ST_DROP_B: sel = 1'b1;
      default:              sel = 1'b0;
    endcase
    hdr = pkt_hdr(d_dout[sel]);
    if (state_q == ST_IDLE) begin
      // The head is popped from IDLE itself; out_wr_q holds off one cycle after a tail.
      if (!out_wr_q && want != 2'b00) begin
        d_rd[sel] = 1'b1;
        if (f_head[sel] && hdr == PKT_HEAD) begin
          emit    = 1'b1;
          state_d = sel ? ST_SEND_B : ST_SEND_A;
        end else if (hdr == PKT_TAIL) begin
          f_rd[sel] = 1'b1;
          rr_d      = ~sel;
        end else begin
          state_d = sel ? ST_DROP_B : ST_DROP_A;
        end
      end
    end else if (!d_empty[sel]) begin
      d_rd[sel] = 1'b1;
      emit      = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
      if (hdr == PKT_TAIL) begin
        f_rd[sel] = 1'b1;
        rr_d      = ~sel;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      alf_q      <= '0;
      ovf_q      <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_vwr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      alf_q     <= alf_d;
      if (any_ovf && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      out_wr_q  <= emit;
      if (emit) out_data_q <= d_dout[sel];
      out_vld_q <= emit && hdr == PKT_TAIL && f_head[sel];
      out_vwr_q <= emit && hdr == PKT_TAIL;
    end
  end

  assign a_if.data_alf        = alf_q[0];
  assign b_if.data_alf        = alf_q[1];
  assign out_if.data_wr       = out_wr_q;
  assign out_if.data          = out_data_q;
  assign out_if.data_valid    = out_vld_q;
  assign out_if.data_valid_wr = out_vwr_q;
  assign ovf_cnt              = ovf_q;
endmodule

// File: tb/tb_ptp_pkt_mux.sv
// Scoreboard bench for ptp_pkt_mux: expected words queued at drive time, checked on egress.
module tb_ptp_pkt_mux;
  import ptp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ovf_cnt;

  ptp_pkt_mux_if a_if ();
  ptp_pkt_mux_if b_if ();
  ptp_pkt_mux_if out_if ();

  ptp_pkt_mux u_dut (
    .clk(clk), .rst_n(rst_n), .a_if(a_if), .b_if(b_if), .out_if(out_if), .ovf_cnt(ovf_cnt));

  always #5 clk = ~clk;

  int        n_cmp = 0;
  int        n_err = 0;
  int        pid   = 0;
  bit        mon_en = 1'b1;
  logic      prev_wr = 1'b0;
  pkt_word_t sb_q [$];

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic pkt_word_t mkw(input int port, input int id, input int idx, input int n);
    logic [1:0] h;
    h = (idx == 0) ? PKT_HEAD : ((idx == n - 1) ? PKT_TAIL : PKT_BODY);
    return {h, 84'h0, 16'(port), 16'(id), 16'(idx)};
  endfunction

  task automatic idle_in();
    a_if.data_wr = 1'b0; a_if.data_valid_wr = 1'b0; a_if.data_valid = 1'b0; a_if.data = '0;
    b_if.data_wr = 1'b0; b_if.data_valid_wr = 1'b0; b_if.data_valid = 1'b0; b_if.data = '0;
  endtask

  task automatic push(input bit en, input int port, input int id, input int n);
    if (en) for (int i = 0; i < n; i++) sb_q.push_back(mkw(port, id, i, n));
  endtask

  // Drive n-word packets on the enabled ports in lockstep; flag coincident with tail.
  task automatic pkts(input bit ea, input bit eb, input int n, input bit va, input bit vb,
                      input bit b_first);
    int ida, idb;
    ida = pid; idb = pid + 1; pid += 2;
    if (b_first) begin push(eb && vb, 1, idb, n); push(ea && va, 0, ida, n); end
    else         begin push(ea && va, 0, ida, n); push(eb && vb, 1, idb, n); end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      a_if.data_wr = ea; a_if.data = mkw(0, ida, i, n);
      a_if.data_valid = va; a_if.data_valid_wr = ea && (i == n - 1);
      b_if.data_wr = eb; b_if.data = mkw(1, idb, i, n);
      b_if.data_valid = vb; b_if.data_valid_wr = eb && (i == n - 1);
    end
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 500) begin @(negedge clk); c++; end
    chk(tag, 134'(sb_q.size()), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    pkt_word_t e;
    if (mon_en && out_if.data_wr) begin
      chk("sb_has_entry", 134'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("out_data", out_if.data, e);
        chk("out_vwr", out_if.data_valid_wr, 134'(pkt_hdr(e) == PKT_TAIL));
        if (pkt_hdr(e) == PKT_TAIL) chk("out_valid", out_if.data_valid, 1);
        if (pkt_hdr(e) == PKT_HEAD) chk("pkt_gap", prev_wr, 0);
      end
    end
    prev_wr = out_if.data_wr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, c;
    idle_in();
    out_if.data_alf = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_wr",    out_if.data_wr, 0);
    chk("rst_data",  out_if.data, 0);
    chk("rst_valid", out_if.data_valid, 0);
    chk("rst_vwr",   out_if.data_valid_wr, 0);
    chk("rst_alf_a", a_if.data_alf, 0);
    chk("rst_alf_b", b_if.data_alf, 0);
    chk("rst_ovf",   ovf_cnt, 0);
    rst_n = 1'b1;

    // Single A packet, first word two cycles after the flag write.
    pkts(1, 0, 4, 1, 0, 0);
    @(negedge clk); chk("lat_c1", out_if.data_wr, 0);
    @(negedge clk); chk("lat_c2", out_if.data_wr, 1);
    wait_drain("t1_drain");

    // Contention: A first after reset, then A again, then an A-only packet flips priority to B.
    do_reset();
    pkts(1, 1, 3, 1, 1, 0);
    wait_drain("t2_pair1");
    pkts(1, 1, 3, 1, 1, 0);
    wait_drain("t2_pair2");
    pkts(1, 0, 3, 1, 0, 0);
    wait_drain("t2_aonly");
    pkts(1, 1, 3, 1, 1, 1);
    wait_drain("t2_bfirst");

    // Dropped B packet, then A, then a good B proves B's FIFOs drained cleanly.
    pkts(0, 1, 4, 0, 0, 0);
    pkts(1, 0, 3, 1, 0, 0);
    pkts(0, 1, 3, 0, 1, 0);
    wait_drain("t3_drain");
    chk("t3_alf_b", b_if.data_alf, 0);

    // Downstream back-pressure holds start but not an in-flight packet.
    out_if.data_alf = 1'b1;
    pkts(1, 0, 8, 1, 0, 0);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(out_if.data_wr); end
    chk("alf_hold", 134'(cnt), 0);
    @(posedge clk); #1; out_if.data_alf = 1'b0;
    @(negedge clk); chk("alf_rel_c0", out_if.data_wr, 0);
    @(negedge clk); chk("alf_rel_c1", out_if.data_wr, 1);
    repeat (2) @(posedge clk); #1; out_if.data_alf = 1'b1;
    wait_drain("t4_midpkt");
    out_if.data_alf = 1'b0;

    // Fill A without a flag: almost-full after word 157, overflow past 256.
    for (int i = 1; i <= 260; i++) begin
      @(posedge clk); #1;
      if (i - 1 == 156) chk("alf_a_156", a_if.data_alf, 0);
      if (i - 1 == 157) chk("alf_a_157", a_if.data_alf, 1);
      if (i <= 259) begin a_if.data_wr = 1'b1; a_if.data = mkw(0, 99, 1, 3); end
      else idle_in();
    end
    chk("ovf_3", ovf_cnt, 3);
    chk("alf_b_quiet", b_if.data_alf, 0);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1; b_if.data_wr = 1'b1; b_if.data = mkw(1, 99, 1, 3);
    end
    @(posedge clk); #1;
    chk("alf_b_full", b_if.data_alf, 1);
    a_if.data_wr = 1'b1; a_if.data = mkw(0, 98, 1, 3);
    @(posedge clk); #1; idle_in();
    chk("ovf_both_one", ovf_cnt, 4);

    // Reset in the middle of an A packet; only later packets may appear.
    do_reset();
    chk("post_rst_ovf",   ovf_cnt, 0);
    chk("post_rst_alf_a", a_if.data_alf, 0);
    mon_en = 1'b0;
    pkts(1, 0, 8, 1, 0, 0);
    sb_q.delete();
    c = 0;
    while (!out_if.data_wr && c < 50) begin @(negedge clk); c++; end
    chk("t6_started", out_if.data_wr, 1);
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b0; #1;
    chk("t6_rst_wr",   out_if.data_wr, 0);
    chk("t6_rst_data", out_if.data, 0);
    chk("t6_rst_vwr",  out_if.data_valid_wr, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    pkts(0, 1, 3, 0, 1, 0);
    wait_drain("t6_drain");
    repeat (20) @(negedge clk);

    chk("sb_end", 134'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
